// File: rtl/jpeg_zz_quantizer.sv
// rtl/jpeg_zz_quantizer.sv - zigzag-order coefficient quantiser, reciprocal multiply, 3-stage all-stall pipe
// Optional double-buffered table: define QT_DOUBLE_BUF_EN.
module jpeg_zz_quantizer #(
  parameter int DW    = 12,
  parameter int RW    = 16,
  parameter int NCOEF = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic                 qt_we,
  input  logic [$clog2(NCOEF)-1:0] qt_addr,
  input  logic [RW-1:0]        qt_wdata,
  input  logic                 qt_swap,
  output logic signed [DW-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [$clog2(NCOEF)-1:0] dout_idx,
  output logic                 dout_last
);
  localparam int IW = $clog2(NCOEF);
  localparam logic [DW+RW-1:0] HALF = (DW+RW)'(1) << (RW-1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCOEF-1);

  logic          w_adv, w_xfer;
  logic [RW-1:0] w_recip;
  logic [IW-1:0] r_idx;

  logic                 r_s1_valid, r_s2_valid, r_s3_valid;
  logic signed [DW-1:0] r_s1_din;
  logic [IW-1:0]        r_s1_idx, r_s2_idx, r_s3_idx;
  logic [RW-1:0]        r_s1_recip;
  logic [DW+RW-1:0]     r_s2_mag;
  logic                 r_s2_sign;
  logic signed [DW-1:0] r_dout;
  logic                 r_last;

  logic [DW-1:0]    w_abs;
  logic [DW+RW-1:0] w_prod;
  logic [DW-1:0]    w_q;

  assign w_adv     = ~r_s3_valid | dout_ready;
  assign w_xfer    = din_valid & w_adv;
  assign din_ready = w_adv;

`ifdef QT_DOUBLE_BUF_EN
  logic [RW-1:0] r_tbl0 [NCOEF];
  logic [RW-1:0] r_tbl1 [NCOEF];
  logic          r_bank, r_swap_pend, w_do_swap;

  // Swap only at a block boundary so each block sees one table.
  assign w_do_swap = r_swap_pend &
                     ((w_xfer & (r_idx == LAST_IDX)) | ((r_idx == '0) & ~w_xfer));
  assign w_recip   = r_bank ? r_tbl1[r_idx] : r_tbl0[r_idx];

  always_ff @(posedge clk) begin
    if (qt_we) begin
      if (r_bank) r_tbl0[qt_addr] <= qt_wdata;
      else        r_tbl1[qt_addr] <= qt_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bank      <= 1'b0;
      r_swap_pend <= 1'b0;
    end else if (w_do_swap) begin
      r_bank      <= ~r_bank;
      r_swap_pend <= qt_swap;
    end else if (qt_swap) begin
      r_swap_pend <= 1'b1;
    end
  end
`else
  logic [RW-1:0] r_tbl [NCOEF];
  logic          w_unused;

  assign w_recip  = r_tbl[r_idx];
  assign w_unused = qt_swap;

  always_ff @(posedge clk) begin
    if (qt_we) r_tbl[qt_addr] <= qt_wdata;
  end
`endif

  // Magnitude as DW-bit unsigned: |-2^(DW-1)| = 2^(DW-1) still fits.
  assign w_abs  = r_s1_din[DW-1] ? DW'(-r_s1_din) : DW'(r_s1_din);
  assign w_prod = (DW+RW)'(w_abs) * (DW+RW)'(r_s1_recip);
  assign w_q    = DW'((r_s2_mag + HALF) >> RW);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx <= '0;
    end else if (w_xfer) begin
      r_idx <= r_idx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_din   <= '0;
      r_s1_idx   <= '0;
      r_s1_recip <= '0;
      r_s2_valid <= 1'b0;
      r_s2_mag   <= '0;
      r_s2_sign  <= 1'b0;
      r_s2_idx   <= '0;
      r_s3_valid <= 1'b0;
      r_s3_idx   <= '0;
      r_dout     <= '0;
      r_last     <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= din_valid;
      r_s1_din   <= din;
      r_s1_idx   <= r_idx;
      r_s1_recip <= w_recip;
      r_s2_valid <= r_s1_valid;
      r_s2_mag   <= w_prod;
      r_s2_sign  <= r_s1_din[DW-1];
      r_s2_idx   <= r_s1_idx;
      r_s3_valid <= r_s2_valid;
      r_s3_idx   <= r_s2_idx;
      r_dout     <= r_s2_sign ? -$signed(w_q) : $signed(w_q);
      r_last     <= (r_s2_idx == LAST_IDX);
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_s3_valid;
  assign dout_idx   = r_s3_idx;
  assign dout_last  = r_last;

endmodule
